// File: rtl/targ_fb_queue.sv
// targ_fb_queue: buffers resolved indirect-jump outcomes, drops duplicates and
// serialises them one per cycle into the target-predictor feedback port.
package core;
  localparam int pc_w = 32;
  typedef struct packed {
    logic            valid;
    logic [pc_w-1:0] base_pc;
    logic [pc_w-1:0] targ_pc;
  } targ_pred_fb_t;
endpackage

module targ_fb_queue #(
  parameter int res_ports = 2,
  parameter int depth     = 8,
  parameter int pc_width  = core::pc_w
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en_i,
  input  logic                                clr_i,
  input  logic [res_ports-1:0]                res_valid_i,
  input  logic [res_ports-1:0][pc_width-1:0]  res_base_pc_i,
  input  logic [res_ports-1:0][pc_width-1:0]  res_targ_pc_i,
  output logic [res_ports-1:0]                res_ready_o,
  output core::targ_pred_fb_t                 targ_pred_fb_o,
  output logic [$clog2(depth+1)-1:0]          count_o,
  output logic                                full_o,
  output logic                                empty_o
);
  localparam int pw = $clog2(depth);
  localparam int cw = $clog2(depth+1);
  logic [pc_width-1:0] base_q [depth];
  logic [pc_width-1:0] targ_q [depth];
  logic [pw-1:0] head_q, head_d, tail_q, tail_d;
  logic [cw-1:0] count_q, count_d;
  logic [depth-1:0] occ;
  logic [res_ports-1:0] dup, acc;
  logic [pw-1:0] widx [res_ports];
  logic pop;
  int free, nd, push_n;
  // An entry is live when its distance from head is below count.
  for (genvar g = 0; g < depth; g++) begin : g_occ
    assign occ[g] = ((g >= int'(head_q)) ? g - int'(head_q) : g + depth - int'(head_q)) < int'(count_q);
  end
  always_comb begin
    pop = en_i && count_q != '0 && !clr_i;
    free = depth - int'(count_q) + int'(pop);
    nd = 0;
    dup = '0;
    acc = '0;
    for (int i = 0; i < res_ports; i++) begin
      widx[i] = '0;
      for (int e = 0; e < depth; e++)
        if (occ[e] && base_q[e] == res_base_pc_i[i] && targ_q[e] == res_targ_pc_i[i]) dup[i] = res_valid_i[i];
      for (int j = 0; j < i; j++)
        if (res_valid_i[j] && !dup[j] && res_base_pc_i[j] == res_base_pc_i[i] && res_targ_pc_i[j] == res_targ_pc_i[i]) dup[i] = res_valid_i[i];
      if (res_valid_i[i] && !dup[i]) begin
        acc[i] = nd < free;
        widx[i] = pw'((int'(tail_q) + nd) % depth);
        nd++;
      end
    end
    push_n = (nd < free) ? nd : free;
  end
  assign head_d  = pop ? ((int'(head_q) == depth-1) ? '0 : head_q + 1'b1) : head_q;
  assign tail_d  = pw'((int'(tail_q) + push_n) % depth);
  assign count_d = cw'(int'(count_q) + push_n - int'(pop));
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < depth; e++) begin
        base_q[e] <= '0;
        targ_q[e] <= '0;
      end
    end else if (clr_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < res_ports; i++)
        if (acc[i]) begin
          base_q[widx[i]] <= res_base_pc_i[i];
          targ_q[widx[i]] <= res_targ_pc_i[i];
        end
    end
  end
  assign res_ready_o    = (dup | acc) & {res_ports{!clr_i && !rst}};
  assign targ_pred_fb_o = '{valid: pop, base_pc: base_q[head_q], targ_pc: targ_q[head_q]};
  assign count_o        = count_q;
  assign full_o         = count_q == cw'(depth);
  assign empty_o        = count_q == '0;
  a_count_le_depth: assert property (@(posedge clk) disable iff (rst) count_q <= cw'(depth));
endmodule

// File: tb/tb_targ_fb_queue.sv
// tb_targ_fb_queue: vector table plus hand sequences; a scoreboard queue holds
// the outcomes expected to come out of the feedback port, in order.
module tb_targ_fb_queue;
  logic clk = 1'b0;
  logic rst, en, clr;
  logic [1:0] rv, rdy;
  logic [1:0][31:0] rb, rt;
  core::targ_pred_fb_t fb;
  logic [3:0] cnt;
  logic full, empty;
  int n_chk = 0, n_fail = 0;
  logic [63:0] sb [$];

  typedef struct {
    logic e, c;
    logic [1:0] v;
    logic [31:0] b0, t0, b1, t1;
    logic [1:0] rdy;
    int cnt;
    logic fbv;
    logic [1:0] push;
  } vec_t;
  vec_t tbl [$];

  targ_fb_queue #(.res_ports(2), .depth(8), .pc_width(32)) dut (
    .clk(clk), .rst(rst), .en_i(en), .clr_i(clr), .res_valid_i(rv),
    .res_base_pc_i(rb), .res_targ_pc_i(rt), .res_ready_o(rdy),
    .targ_pred_fb_o(fb), .count_o(cnt), .full_o(full), .empty_o(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic e, c, input logic [1:0] v,
                              input logic [31:0] b0, t0, b1, t1,
                              input logic [1:0] r, input int n, input logic f, input logic [1:0] p);
    vec_t x;
    x.e = e; x.c = c; x.v = v; x.b0 = b0; x.t0 = t0; x.b1 = b1; x.t1 = t1;
    x.rdy = r; x.cnt = n; x.fbv = f; x.push = p;
    return x;
  endfunction

  // Called at posedge+1; checks at negedge, then advances to the next posedge+1.
  task automatic cyc(input vec_t x);
    logic [63:0] exp_pair;
    en = x.e; clr = x.c; rv = x.v;
    rb[0] = x.b0; rt[0] = x.t0; rb[1] = x.b1; rt[1] = x.t1;
    @(negedge clk);
    chk("res_ready", 64'(rdy), 64'(x.rdy));
    chk("count", 64'(cnt), 64'(x.cnt));
    chk("empty", 64'(empty), 64'(x.cnt == 0));
    chk("full", 64'(full), 64'(x.cnt == 8));
    chk("fb_valid", 64'(fb.valid), 64'(x.fbv));
    if (x.fbv && fb.valid) begin
      if (sb.size() == 0) chk("scoreboard_nonempty", 64'(0), 64'(1));
      else begin
        exp_pair = sb.pop_front();
        chk("fb_pair", {fb.base_pc, fb.targ_pc}, exp_pair);
      end
    end
    if (x.push[0]) sb.push_back({x.b0, x.t0});
    if (x.push[1]) sb.push_back({x.b1, x.t1});
    if (x.c) sb.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; clr = 1'b0; rv = 2'b11;
    rb[0] = 32'h100; rt[0] = 32'h200; rb[1] = 32'h300; rt[1] = 32'h400;
    @(negedge clk);
    chk("rst_ready", 64'(rdy), 64'(0));
    chk("rst_fb_valid", 64'(fb.valid), 64'(0));
    chk("rst_fb_pcs", {fb.base_pc, fb.targ_pc}, 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_count", 64'(cnt), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;

    // single outcome, one-cycle latency, then empty
    tbl.push_back(mk(1, 0, 2'b01, 32'h100, 32'h200, 0, 0, 2'b01, 0, 0, 2'b01));
    tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 1, 2'b00));
    tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
    // same-cycle and queued duplicates
    tbl.push_back(mk(0, 0, 2'b11, 32'h100, 32'h200, 32'h100, 32'h200, 2'b11, 0, 0, 2'b01));
    tbl.push_back(mk(0, 0, 2'b01, 32'h100, 32'h200, 0, 0, 2'b01, 1, 0, 2'b00));
    tbl.push_back(mk(0, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 0, 2'b00));
    tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 1, 2'b00));
    tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
    // fill to full, backpressure, pop frees exactly one slot in the same cycle
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0, 0, 2'b11, 32'h10 + 32'(32*k), 32'h11 + 32'(32*k),
                       32'h20 + 32'(32*k), 32'h21 + 32'(32*k), 2'b11, 2*k, 0, 2'b11));
    tbl.push_back(mk(0, 0, 2'b01, 32'h99, 32'h9a, 0, 0, 2'b00, 8, 0, 2'b00));
    tbl.push_back(mk(1, 0, 2'b11, 32'h99, 32'h9a, 32'h98, 32'h9b, 2'b01, 8, 1, 2'b01));
    tbl.push_back(mk(0, 0, 2'b10, 0, 0, 32'h98, 32'h9b, 2'b00, 8, 0, 2'b00));
    tbl.push_back(mk(0, 0, 2'b01, 32'h20, 32'h21, 0, 0, 2'b01, 8, 0, 2'b00));
    for (int k = 0; k < 8; k++)
      tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 8 - k, 1, 2'b00));
    tbl.push_back(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
    foreach (tbl[i]) cyc(tbl[i]);

    // order across pointer wrap: head/tail now sit mid-buffer
    for (int k = 0; k < 4; k++)
      cyc(mk(0, 0, 2'b11, 32'hA000 + 32'(k), 32'hA100 + 32'(k),
             32'hB000 + 32'(k), 32'hB100 + 32'(k), 2'b11, 2*k, 0, 2'b11));
    for (int k = 0; k < 8; k++)
      cyc(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 8 - k, 1, 2'b00));
    cyc(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));

    // clear with five queued and a valid request pending
    cyc(mk(0, 0, 2'b11, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 2'b11, 0, 0, 2'b11));
    cyc(mk(0, 0, 2'b11, 32'hC4, 32'hC5, 32'hC6, 32'hC7, 2'b11, 2, 0, 2'b11));
    cyc(mk(0, 0, 2'b01, 32'hC8, 32'hC9, 0, 0, 2'b01, 4, 0, 2'b01));
    cyc(mk(1, 1, 2'b01, 32'hD0, 32'hD1, 0, 0, 2'b00, 5, 0, 2'b00));
    cyc(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
    cyc(mk(1, 0, 2'b01, 32'hD0, 32'hD1, 0, 0, 2'b01, 0, 0, 2'b01));
    cyc(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 1, 2'b00));

    // asynchronous reset mid-cycle discards queued outcomes
    cyc(mk(0, 0, 2'b11, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 2'b11, 0, 0, 2'b11));
    en = 1'b1; rv = 2'b11;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_count", 64'(cnt), 64'(0));
    chk("arst_ready", 64'(rdy), 64'(0));
    chk("arst_fb_valid", 64'(fb.valid), 64'(0));
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc(mk(1, 0, 2'b01, 32'hF0, 32'hF1, 0, 0, 2'b01, 0, 0, 2'b01));
    cyc(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 1, 1, 2'b00));
    cyc(mk(1, 0, 2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 2'b00));
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
